// File: rtl/std_seq_checker.sv
// Receive-side checker for the 8-symbol 3-bit state sequence: locks on, tracks position, flags and counts errors.
// Optional sticky error flag with synchronous clear is enabled by defining STD_SEQ_STICKY_EN.
module std_seq_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       std_in,
    input  logic             std_valid,
`ifdef STD_SEQ_STICKY_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             locked,
    output logic [2:0]       pos,
    output logic             err,
    output logic             seq_wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [2:0]       pos_n, exp_idx, exp_n, good, good_n, miss, miss_n, idx;
    logic             err_n, wrap_n;
    logic [CNT_W-1:0] cnt_n;
`ifdef STD_SEQ_STICKY_EN
    logic             sticky_n;
`endif

    // std_valid qualifies std_in; there is no backpressure, so every valid sample is consumed on that edge.
    always_comb begin
        idx = 3'd0;
        case (std_in)
            3'b000: idx = 3'd0;
            3'b010: idx = 3'd1;
            3'b111: idx = 3'd2;
            3'b100: idx = 3'd3;
            3'b101: idx = 3'd4;
            3'b001: idx = 3'd5;
            3'b011: idx = 3'd6;
            3'b110: idx = 3'd7;
            default: idx = 3'd0;
        endcase
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        exp_n   = exp_idx;
        good_n  = good;
        miss_n  = miss;
        err_n   = 1'b0;
        wrap_n  = 1'b0;
        cnt_n   = err_cnt;
        if (std_valid) begin
            case (state)
                HUNT: begin
                    pos_n   = idx;
                    exp_n   = idx + 3'd1;
                    good_n  = 3'd0;
                    state_n = SYNC;
                end
                SYNC: begin
                    pos_n = idx;
                    exp_n = idx + 3'd1;
                    if (idx == exp_idx) begin
                        good_n = good + 3'd1;
                        if (good + 3'd1 == 3'(LOCK_CNT)) begin
                            state_n = LOCKED;
                            miss_n  = 3'd0;
                        end
                    end else begin
                        good_n = 3'd0;
                    end
                end
                LOCKED: begin
                    if (idx == exp_idx) begin
                        pos_n  = idx;
                        exp_n  = idx + 3'd1;
                        miss_n = 3'd0;
                        wrap_n = (idx == 3'd0);
                    end else begin
                        // Flywheel: advance on the local expectation and discard the received symbol.
                        pos_n  = exp_idx;
                        exp_n  = exp_idx + 3'd1;
                        err_n  = 1'b1;
                        miss_n = miss + 3'd1;
                        if (miss + 3'd1 == 3'(UNLOCK_CNT)) begin
                            state_n = HUNT;
                            miss_n  = 3'd0;
                            good_n  = 3'd0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
        if (err_n && (err_cnt != {CNT_W{1'b1}}))
            cnt_n = err_cnt + CNT_W'(1);
`ifdef STD_SEQ_STICKY_EN
        sticky_n = err_sticky | err_n;
        // A coincident error beats the clear so no error event is ever lost.
        if (err_clr) begin
            cnt_n    = err_n ? CNT_W'(1) : '0;
            sticky_n = err_n;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            pos      <= 3'd0;
            exp_idx  <= 3'd0;
            good     <= 3'd0;
            miss     <= 3'd0;
            err      <= 1'b0;
            seq_wrap <= 1'b0;
            err_cnt  <= '0;
`ifdef STD_SEQ_STICKY_EN
            err_sticky <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            exp_idx  <= exp_n;
            good     <= good_n;
            miss     <= miss_n;
            err      <= err_n;
            seq_wrap <= wrap_n;
            err_cnt  <= cnt_n;
`ifdef STD_SEQ_STICKY_EN
            err_sticky <= sticky_n;
`endif
        end
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

endmodule

// File: tb/tb_std_seq_checker.sv
// Bench for std_seq_checker: directed and random symbol streams scored against a queue-fed reference model.
// Build with STD_SEQ_STICKY_EN defined to also cover the sticky flag and err_clr.
module tb_std_seq_checker;
    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;
`ifdef STD_SEQ_STICKY_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 3;
`endif
    localparam int W = 1 + 3 + 1 + 1 + CNT_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       std_in;
    logic             std_valid;
    logic             err_clr;
    logic             err_sticky;
    logic             locked;
    logic [2:0]       pos;
    logic             err;
    logic             seq_wrap;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int code_tab[8] = '{0, 2, 7, 4, 5, 1, 3, 6};

    // Reference model: mode 0 = hunting, 1 = acquiring, 2 = locked.
    int m_mode, m_pos, m_exp, m_good, m_miss, m_cnt, m_sticky;

    std_seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .std_in(std_in),
        .std_valid(std_valid),
`ifdef STD_SEQ_STICKY_EN
        .err_clr(err_clr),
        .err_sticky(err_sticky),
`endif
        .locked(locked),
        .pos(pos),
        .err(err),
        .seq_wrap(seq_wrap),
        .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

`ifndef STD_SEQ_STICKY_EN
    assign err_sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int idx_of(input int code);
        for (int i = 0; i < 8; i++)
            if (code_tab[i] == code) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_exp = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_sticky = 0;
    endtask

    task automatic model_step(input bit v, input int code, input bit clr, output bit e, output bit w);
        int i;
        int cmax;
        cmax = (1 << CNT_W) - 1;
        e = 1'b0;
        w = 1'b0;
        if (v) begin
            i = idx_of(code);
            if (m_mode == 0) begin
                m_pos = i; m_exp = (i + 1) % 8; m_good = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (i == m_exp) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_good = 0;
                end
                m_pos = i; m_exp = (i + 1) % 8;
            end else begin
                if (i == m_exp) begin
                    m_pos = i; m_exp = (i + 1) % 8; m_miss = 0; w = (i == 0);
                end else begin
                    m_pos = m_exp; m_exp = (m_exp + 1) % 8; e = 1'b1; m_miss++;
                    if (m_miss == UNLOCK_CNT) begin m_mode = 0; m_miss = 0; m_good = 0; end
                end
            end
        end
`ifdef STD_SEQ_STICKY_EN
        if (clr) begin
            m_cnt = e ? 1 : 0;
            m_sticky = e;
        end else begin
            if (e && m_cnt < cmax) m_cnt++;
            if (e) m_sticky = 1;
        end
`else
        if (e && m_cnt < cmax) m_cnt++;
`endif
    endtask

    task automatic drive(input bit v, input int code, input bit clr);
        bit e, w;
        @(negedge clk);
        std_valid = v;
        std_in    = 3'(code);
        err_clr   = clr;
        model_step(v, code, clr, e, w);
        exp_q.push_back({1'(m_mode == 2), 3'(m_pos), e, w, CNT_W'(m_cnt), 1'(m_sticky)});
    endtask

    task automatic send_idx(input int i);
        drive(1'b1, code_tab[i % 8], 1'b0);
    endtask

    task automatic send_wrong(input bit clr);
        drive(1'b1, code_tab[(m_exp + 3) % 8], clr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_pos"}, int'(pos), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_wrap"}, int'(seq_wrap), 0);
        check({tag, "_cnt"}, int'(err_cnt), 0);
`ifdef STD_SEQ_STICKY_EN
        check({tag, "_sticky"}, int'(err_sticky), 0);
`endif
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        std_valid = 1'b0;
        err_clr   = 1'b0;
        rst       = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the following edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("locked", int'(locked), int'(e[W-1]));
                check("pos", int'(pos), int'(e[W-2 -: 3]));
                check("err", int'(err), int'(e[W-5]));
                check("seq_wrap", int'(seq_wrap), int'(e[W-6]));
                check("err_cnt", int'(err_cnt), int'(e[CNT_W:1]));
`ifdef STD_SEQ_STICKY_EN
                check("err_sticky", int'(err_sticky), int'(e[0]));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bit v;
        int code;
        bit clr;
        rst = 1'b0;
        std_valid = 1'b0;
        std_in = 3'd0;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Acquire from 000, run through the wrap and on to pos 2.
        for (int i = 0; i <= 10; i++) send_idx(i);
        // Single wrong symbol (011 instead of 100), then the flywheel-expected 101.
        drive(1'b1, 3, 1'b0);
        send_idx(4);
        // Two consecutive wrong symbols drop lock; four correct ones relock.
        send_wrong(1'b0);
        send_wrong(1'b0);
        for (int i = 5; i < 9; i++) send_idx(i);
        // Gapped valid while locked.
        for (int i = 1; i < 7; i++) begin
            send_idx(i);
            idle(1);
        end
        async_reset("async_rst");

        // Acquire mid-cycle at 101 and wrap through 000.
        for (int i = 4; i < 10; i++) send_idx(i);

`ifdef STD_SEQ_STICKY_EN
        // Isolated errors saturate the counter, then clear, then clear racing an error.
        for (int k = 0; k < 5; k++) begin
            send_wrong(1'b0);
            send_idx(m_exp);
        end
        drive(1'b0, 0, 1'b1);
        send_idx(m_exp);
        send_wrong(1'b1);
        send_idx(m_exp);
`endif

        // Mostly-correct random stream with gaps, errors and occasional clears.
        for (int k = 0; k < 800; k++) begin
            v = ($urandom_range(0, 3) != 0);
            code = ($urandom_range(0, 9) < 8) ? code_tab[m_exp] : code_tab[$urandom_range(0, 7)];
`ifdef STD_SEQ_STICKY_EN
            clr = ($urandom_range(0, 40) == 0);
`else
            clr = 1'b0;
`endif
            drive(v, code, clr);
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        idle(2);
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
